// File: rtl/csr_pkg.sv
// Shared constants for the scpu CSR/trap file: CSR addresses, privilege codes,
// write-op codes, mstatus bit positions and cause codes. CSR_COUNTERS_EN adds the counter CSRs.
package csr_pkg;

  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEDELEG  = 12'h302;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    WR_OP_NONE  = 2'b00,
    WR_OP_WRITE = 2'b01,
    WR_OP_SET   = 2'b10,
    WR_OP_CLEAR = 2'b11
  } wr_op_e;

  localparam int MSTATUS_SIE    = 1;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_SPIE   = 5;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_SPP    = 8;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [5:0] CAUSE_ILLEGAL_INSTR = 6'd2;
  localparam logic [5:0] CAUSE_ECALL_U       = 6'd8;
  localparam logic [5:0] CAUSE_ECALL_S       = 6'd9;
  localparam logic [5:0] CAUSE_ECALL_M       = 6'd11;

  function automatic logic csr_implemented(input logic [11:0] addr);
    logic impl;
    case (addr)
      CSR_SSTATUS, CSR_STVEC, CSR_SEPC, CSR_SCAUSE, CSR_SATP,
      CSR_MSTATUS, CSR_MEDELEG, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE: impl = 1'b1;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_MINSTRET, CSR_CYCLE, CSR_INSTRET: impl = 1'b1;
`endif
      default: impl = 1'b0;
    endcase
    return impl;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// XLEN-bit free-running counter with a load port; load takes priority over increment.
module csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_val,
  input  logic            inc,
  output logic [XLEN-1:0] count
);

  logic [XLEN-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csr_trap_file.sv
// M/S-mode CSR file with trap entry, mret/sret, privilege tracking and PC redirect.
// Optional feature macro: CSR_COUNTERS_EN (mcycle/minstret and their read-only aliases).
module csr_trap_file
  import csr_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [1:0]      RST_PRIV  = 2'b11,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_illegal,
  input  logic [1:0]      wr_op,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            wr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            xret_valid,
  input  logic            xret_is_m,
`ifdef CSR_COUNTERS_EN
  input  logic            instret_inc,
`endif
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      priv,
  output logic [XLEN-1:0] satp_data
);

  localparam logic [XLEN-1:0] SSTATUS_MASK = {{(XLEN-9){1'b0}}, 9'h122};
  localparam logic [XLEN-1:0] TVEC_MASK    = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] EPC_MASK     = {{(XLEN-1){1'b1}}, 1'b0};

  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d, medeleg_q, medeleg_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] stvec_q, stvec_d, sepc_q, sepc_d, scause_q, scause_d;
  logic [XLEN-1:0] satp_q, satp_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d, redirect_pc_q, redirect_pc_d;
  logic            rd_illegal_q, rd_illegal_d, redirect_valid_q, redirect_valid_d;

  logic            rd_bad_s, wr_commit_s, trap_to_s_s, xret_ok_s;
  logic [XLEN-1:0] wr_old_s, wr_new_s, mstatus_wr_s;
  logic [63:0]     deleg_ext_s;

`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle_s, minstret_s;
  logic            mcycle_load_s, minstret_load_s;
`endif

  function automatic logic [XLEN-1:0] csr_value(input logic [11:0] addr);
    logic [XLEN-1:0] v;
    case (addr)
      CSR_MSTATUS:  v = mstatus_q;
      CSR_SSTATUS:  v = mstatus_q & SSTATUS_MASK;
      CSR_MEDELEG:  v = medeleg_q;
      CSR_MTVEC:    v = mtvec_q;
      CSR_MEPC:     v = mepc_q;
      CSR_MCAUSE:   v = mcause_q;
      CSR_STVEC:    v = stvec_q;
      CSR_SEPC:     v = sepc_q;
      CSR_SCAUSE:   v = scause_q;
      CSR_SATP:     v = satp_q;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_CYCLE:     v = mcycle_s;
      CSR_MINSTRET, CSR_INSTRET: v = minstret_s;
`endif
      default:      v = '0;
    endcase
    return v;
  endfunction

  assign rd_bad_s   = !csr_implemented(rd_addr) || (rd_addr[9:8] > priv_q);
  assign wr_illegal = (wr_op != WR_OP_NONE) &&
                      (!csr_implemented(wr_addr) || (wr_addr[11:10] == 2'b11) ||
                       (wr_addr[9:8] > priv_q));
  assign wr_commit_s = (wr_op != WR_OP_NONE) && !wr_illegal && !trap_valid && !xret_valid;

  // medeleg widened so cause[5:0] can index it for any XLEN
  assign deleg_ext_s = 64'(medeleg_q);
  assign trap_to_s_s = (priv_q != PRIV_M) && deleg_ext_s[trap_cause[5:0]] &&
                       (trap_cause[XLEN-1] == 1'b0);
  assign xret_ok_s   = xret_is_m ? (priv_q == PRIV_M) : (priv_q != PRIV_U);

  always_comb begin
    wr_old_s = csr_value(wr_addr);
    case (wr_op_e'(wr_op))
      WR_OP_WRITE: wr_new_s = wr_data;
      WR_OP_SET:   wr_new_s = wr_old_s | wr_data;
      WR_OP_CLEAR: wr_new_s = wr_old_s & ~wr_data;
      default:     wr_new_s = wr_old_s;
    endcase
    mstatus_wr_s = wr_new_s;
    if (wr_new_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == 2'b10) begin
      mstatus_wr_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
    end else begin
      mstatus_wr_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = wr_new_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
    end
  end

  always_comb begin
    priv_d           = priv_q;
    mstatus_d        = mstatus_q;
    medeleg_d        = medeleg_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    stvec_d          = stvec_q;
    sepc_d           = sepc_q;
    scause_d         = scause_q;
    satp_d           = satp_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    rd_data_d        = rd_data_q;
    rd_illegal_d     = rd_illegal_q;

    if (rd_en) begin
      rd_data_d    = rd_bad_s ? '0 : csr_value(rd_addr);
      rd_illegal_d = rd_bad_s;
    end else begin
      rd_illegal_d = rd_illegal_q;
    end

    if (trap_valid) begin
      redirect_valid_d = 1'b1;
      if (trap_to_s_s) begin
        sepc_d                  = trap_pc & EPC_MASK;
        scause_d                = trap_cause;
        mstatus_d[MSTATUS_SPIE] = mstatus_q[MSTATUS_SIE];
        mstatus_d[MSTATUS_SIE]  = 1'b0;
        mstatus_d[MSTATUS_SPP]  = priv_q[0];
        priv_d                  = PRIV_S;
        redirect_pc_d           = stvec_q;
      end else begin
        mepc_d                  = trap_pc & EPC_MASK;
        mcause_d                = trap_cause;
        mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
        mstatus_d[MSTATUS_MIE]  = 1'b0;
        mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_q;
        priv_d                  = PRIV_M;
        redirect_pc_d           = mtvec_q;
      end
    end else if (xret_valid) begin
      // an xret from too low a privilege is dropped here; the decoder raises the exception
      if (xret_ok_s && xret_is_m) begin
        redirect_valid_d        = 1'b1;
        priv_d                  = mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
        mstatus_d[MSTATUS_MPIE] = 1'b1;
        mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
        redirect_pc_d           = mepc_q;
      end else if (xret_ok_s) begin
        redirect_valid_d        = 1'b1;
        priv_d                  = {1'b0, mstatus_q[MSTATUS_SPP]};
        mstatus_d[MSTATUS_SIE]  = mstatus_q[MSTATUS_SPIE];
        mstatus_d[MSTATUS_SPIE] = 1'b1;
        mstatus_d[MSTATUS_SPP]  = 1'b0;
        redirect_pc_d           = sepc_q;
      end else begin
        redirect_valid_d        = 1'b0;
      end
    end else if (wr_commit_s) begin
      case (wr_addr)
        CSR_MSTATUS: mstatus_d = mstatus_wr_s;
        CSR_SSTATUS: mstatus_d = (mstatus_q & ~SSTATUS_MASK) | (wr_new_s & SSTATUS_MASK);
        CSR_MEDELEG: medeleg_d = wr_new_s;
        CSR_MTVEC:   mtvec_d   = wr_new_s & TVEC_MASK;
        CSR_MEPC:    mepc_d    = wr_new_s & EPC_MASK;
        CSR_MCAUSE:  mcause_d  = wr_new_s;
        CSR_STVEC:   stvec_d   = wr_new_s & TVEC_MASK;
        CSR_SEPC:    sepc_d    = wr_new_s & EPC_MASK;
        CSR_SCAUSE:  scause_d  = wr_new_s;
        CSR_SATP:    satp_d    = wr_new_s;
        default:     satp_d    = satp_q;
      endcase
    end else begin
      redirect_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      priv_q           <= RST_PRIV;
      mstatus_q        <= '0;
      medeleg_q        <= '0;
      mtvec_q          <= MTVEC_RST;
      mepc_q           <= '0;
      mcause_q         <= '0;
      stvec_q          <= '0;
      sepc_q           <= '0;
      scause_q         <= '0;
      satp_q           <= '0;
      rd_data_q        <= '0;
      rd_illegal_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      priv_q           <= priv_d;
      mstatus_q        <= mstatus_d;
      medeleg_q        <= medeleg_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      stvec_q          <= stvec_d;
      sepc_q           <= sepc_d;
      scause_q         <= scause_d;
      satp_q           <= satp_d;
      rd_data_q        <= rd_data_d;
      rd_illegal_q     <= rd_illegal_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  assign mcycle_load_s   = wr_commit_s && (wr_addr == CSR_MCYCLE);
  assign minstret_load_s = wr_commit_s && (wr_addr == CSR_MINSTRET);

  csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk      (clk),
    .rst      (rst),
    .load     (mcycle_load_s),
    .load_val (wr_new_s),
    .inc      (1'b1),
    .count    (mcycle_s)
  );

  csr_counter #(.XLEN(XLEN)) u_minstret (
    .clk      (clk),
    .rst      (rst),
    .load     (minstret_load_s),
    .load_val (wr_new_s),
    .inc      (instret_inc),
    .count    (minstret_s)
  );
`endif

  assign rd_data        = rd_data_q;
  assign rd_illegal     = rd_illegal_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign priv           = priv_q;
  assign satp_data      = satp_q;

endmodule

// File: tb/tb_csr_trap_file.sv
// Scoreboard bench for csr_trap_file: expectations are queued as stimulus is driven
// and popped against the DUT outputs once they are due.
module tb_csr_trap_file;
  import csr_pkg::*;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            rd_en;
  logic [11:0]     rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_illegal;
  logic [1:0]      wr_op;
  logic [11:0]     wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            wr_illegal;
  logic            trap_valid;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            xret_valid;
  logic            xret_is_m;
  logic            instret_inc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0]      priv;
  logic [XLEN-1:0] satp_data;

  csr_trap_file #(
    .XLEN      (XLEN),
    .RST_PRIV  (2'b11),
    .MTVEC_RST (64'h0000_0000_8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_illegal     (rd_illegal),
    .wr_op          (wr_op),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_illegal     (wr_illegal),
    .trap_valid     (trap_valid),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .xret_valid     (xret_valid),
    .xret_is_m      (xret_is_m),
`ifdef CSR_COUNTERS_EN
    .instret_inc    (instret_inc),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .priv           (priv),
    .satp_data      (satp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop(input logic [63:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: observed %h with no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [63:0] exp_data, input logic exp_ill);
    rd_en   = 1'b1;
    rd_addr = addr;
    push($sformatf("rd_data_%h", addr), exp_data);
    push($sformatf("rd_ill_%h", addr), 64'(exp_ill));
    tick();
    rd_en = 1'b0;
    pop(rd_data);
    pop(64'(rd_illegal));
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] data,
                    input logic exp_ill);
    wr_op   = op;
    wr_addr = addr;
    wr_data = data;
    push($sformatf("wr_ill_%h", addr), 64'(exp_ill));
    #1;
    pop(64'(wr_illegal));
    tick();
    wr_op = 2'b00;
  endtask

  task automatic trap(input logic [63:0] cause, input logic [63:0] pc,
                      input logic [63:0] exp_pc, input logic [1:0] exp_priv);
    trap_valid = 1'b1;
    trap_cause = cause;
    trap_pc    = pc;
    push("trap_redir_v", 64'd1);
    push("trap_redir_pc", exp_pc);
    push("trap_priv", 64'(exp_priv));
    tick();
    trap_valid = 1'b0;
    pop(64'(redirect_valid));
    pop(redirect_pc);
    pop(64'(priv));
  endtask

  task automatic xret(input logic is_m, input logic exp_v, input logic [63:0] exp_pc,
                      input logic [1:0] exp_priv);
    xret_valid = 1'b1;
    xret_is_m  = is_m;
    push("xret_redir_v", 64'(exp_v));
    push("xret_priv", 64'(exp_priv));
    tick();
    xret_valid = 1'b0;
    pop(64'(redirect_valid));
    pop(64'(priv));
    if (exp_v) begin
      push("xret_redir_pc", exp_pc);
      pop(redirect_pc);
    end
  endtask

  task automatic idle_no_redirect();
    push("redir_drop", 64'd0);
    tick();
    pop(64'(redirect_valid));
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_addr = 12'h000; wr_op = 2'b00; wr_addr = 12'h000;
    wr_data = 64'd0; trap_valid = 1'b0; trap_cause = 64'd0; trap_pc = 64'd0;
    xret_valid = 1'b0; xret_is_m = 1'b0; instret_inc = 1'b0;
    #12;
    push("rst_priv", 64'd3);       pop(64'(priv));
    push("rst_rd_data", 64'd0);    pop(rd_data);
    push("rst_rd_ill", 64'd0);     pop(64'(rd_illegal));
    push("rst_redir_v", 64'd0);    pop(64'(redirect_valid));
    push("rst_redir_pc", 64'd0);   pop(redirect_pc);
    @(negedge clk);
    rst = 1'b0;
    tick();

    rd(CSR_MTVEC, 64'h8000_0000, 1'b0);
    wr(2'b01, CSR_MTVEC, 64'h8000_1003, 1'b0);
    wr(2'b10, CSR_MSTATUS, 64'h8, 1'b0);
    rd(CSR_MTVEC, 64'h8000_1000, 1'b0);
    rd(CSR_MSTATUS, 64'h8, 1'b0);

    // ecall from M: MPIE<-1, MIE<-0, MPP<-11
    trap(64'd11, 64'h8000_0100, 64'h8000_1000, 2'b11);
    idle_no_redirect();
    rd(CSR_MEPC, 64'h8000_0100, 1'b0);
    rd(CSR_MSTATUS, 64'h1880, 1'b0);
    rd(CSR_MCAUSE, 64'd11, 1'b0);

    wr(2'b11, CSR_MSTATUS, 64'h1800, 1'b0);
    wr(2'b01, CSR_MEPC, 64'h8000_0201, 1'b0);
    wr(2'b01, CSR_STVEC, 64'h8000_2003, 1'b0);
    wr(2'b01, CSR_MEDELEG, 64'h100, 1'b0);
    rd(CSR_MEPC, 64'h8000_0200, 1'b0);
    xret(1'b1, 1'b1, 64'h8000_0200, 2'b00);

    // U mode: M CSRs out of reach, sret ignored
    wr(2'b01, CSR_MSTATUS, 64'h0, 1'b1);
    rd(CSR_MSTATUS, 64'h0, 1'b1);
    xret(1'b0, 1'b0, 64'h0, 2'b00);

    trap(64'd8, 64'h8000_0300, 64'h8000_2000, 2'b01);
    rd(CSR_SEPC, 64'h8000_0300, 1'b0);
    rd(CSR_SCAUSE, 64'd8, 1'b0);
    rd(CSR_SSTATUS, 64'h0, 1'b0);
    rd(CSR_MSTATUS, 64'h0, 1'b1);
    wr(2'b10, CSR_SSTATUS, 64'h28, 1'b0);
    rd(CSR_SSTATUS, 64'h20, 1'b0);
    xret(1'b1, 1'b0, 64'h0, 2'b01);
    xret(1'b0, 1'b1, 64'h8000_0300, 2'b00);

    // back-to-back traps; the second collides with an mtvec write that must be dropped
    trap(64'd2, 64'h8000_0500, 64'h8000_1000, 2'b11);
    wr_op = 2'b01; wr_addr = CSR_MTVEC; wr_data = 64'h1234_5678;
    trap(64'd11, 64'h8000_0400, 64'h8000_1000, 2'b11);
    wr_op = 2'b00;
    idle_no_redirect();
    rd(CSR_MTVEC, 64'h8000_1000, 1'b0);
    rd(CSR_MEPC, 64'h8000_0400, 1'b0);
    rd(CSR_MCAUSE, 64'd11, 1'b0);
    rd(CSR_MSTATUS, 64'h1822, 1'b0);

    // read and write of the same CSR in one cycle returns the old value
    wr_op = 2'b01; wr_addr = CSR_MTVEC; wr_data = 64'h8000_4000;
    rd(CSR_MTVEC, 64'h8000_1000, 1'b0);
    wr_op = 2'b00;
    rd(CSR_MTVEC, 64'h8000_4000, 1'b0);

    wr(2'b01, CSR_MSTATUS, 64'h1000, 1'b0);
    rd(CSR_MSTATUS, 64'h0, 1'b0);
    wr(2'b10, CSR_MSTATUS, 64'h0, 1'b0);
    rd(CSR_MSTATUS, 64'h0, 1'b0);
    rd(12'h123, 64'h0, 1'b1);
    wr(2'b01, CSR_CYCLE, 64'h5, 1'b1);

    wr(2'b01, CSR_SATP, 64'h8000_0000_0000_1234, 1'b0);
    push("satp_data", 64'h8000_0000_0000_1234);
    pop(satp_data);

`ifdef CSR_COUNTERS_EN
    wr(2'b01, CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    tick(); tick(); tick();
    rd(CSR_MCYCLE, 64'd1, 1'b0);
`else
    rd(CSR_MCYCLE, 64'h0, 1'b1);
    wr(2'b01, CSR_MCYCLE, 64'h1, 1'b1);
`endif

    // asynchronous reset right after a trap drops the pending redirect at once
    trap_valid = 1'b1; trap_cause = 64'd11; trap_pc = 64'h8000_0600;
    tick();
    trap_valid = 1'b0;
    rst = 1'b1;
    #1;
    push("async_redir_v", 64'd0); pop(64'(redirect_valid));
    push("async_redir_pc", 64'd0); pop(redirect_pc);
    push("async_priv", 64'd3);    pop(64'(priv));
    @(negedge clk);
    rst = 1'b0;
    tick();
    rd(CSR_MTVEC, 64'h8000_0000, 1'b0);
    rd(CSR_MEPC, 64'h0, 1'b0);

    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
